mil_spi_router: RTL and testbench

- Multi-channel command core between the SPI link and CHANNELS MIL-STD-1553 channels.
- Latches each SPI frame header and filters it by block address and channel index.
- Steers SPI receive data into the selected channel's transmit ring buffer, and feeds SPI transmit from that channel's receive buffer or from an internal status generator.
- Drives per-channel ring-buffer open/commit/rollback as frame-scoped transactions, and generates a timed reset request.

---
 rtl/mil_spi_router.sv | 188 ++++++++++++++++++
 tb/tb_mil_spi_router.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mil_spi_router.sv
// Command core between the SPI link and CHANNELS MIL-STD-1553 channels: header filtering,
// data steering into/out of per-channel ring buffers, frame-scoped buffer transactions, reset request.
module mil_spi_router #(
   parameter int          CHANNELS    = 2,
   parameter logic [7:0]  BLOCK_ADDR  = 8'hAB,
   parameter int          DATA_W      = 16,
   parameter int          RESET_PULSE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         frame_end,
   input  logic                         frame_abort,
   input  logic [7:0]                   hdr_addr,
   input  logic [3:0]                   hdr_cmd,
   input  logic [2:0]                   hdr_chan,
   input  logic [DATA_W-1:0]            spi_rx_data,
   input  logic                         spi_rx_req,
   input  logic                         spi_pop_req,
   output logic [DATA_W-1:0]            spi_pop_data,
   output logic                         spi_pop_done,
   output logic [DATA_W-1:0]            spi_tx_size,
   output logic [DATA_W-1:0]            mem_tx_data,
   output logic [CHANNELS-1:0]          mem_tx_req,
   output logic [CHANNELS-1:0]          mem_rx_pop_req,
   input  logic [CHANNELS*DATA_W-1:0]   mem_rx_data,
   input  logic [CHANNELS-1:0]          mem_rx_pop_done,
   input  logic [CHANNELS*DATA_W-1:0]   rx_used,
   output logic [2*CHANNELS-1:0]        buf_open,
   output logic [2*CHANNELS-1:0]        buf_commit,
   output logic [2*CHANNELS-1:0]        buf_rollback,
   output logic [CHANNELS-1:0]          mil_tx_enable,
   output logic                         reset_request
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int RW = $clog2(RESET_PULSE + 1);
   localparam logic [3:0] CMD_RESET = 4'd1;
   localparam logic [3:0] CMD_SEND  = 4'd2;
   localparam logic [3:0] CMD_STS   = 4'd3;
   localparam logic [3:0] CMD_RDATA = 4'd4;
   localparam logic [3:0] STS_LAST  = 4'(CHANNELS + 1);

   typedef enum logic [1:0] {IDLE, SEND, STS, RDATA} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          chan_q, chan_d;
   logic [DATA_W-1:0]      tx_size_q, tx_size_d;
   logic [2*CHANNELS-1:0]  open_q, open_d, commit_q, commit_d, rollback_q, rollback_d;
   logic [3:0]             sts_idx_q, sts_idx_d;
   logic [DATA_W-1:0]      pop_data_q, pop_data_d;
   logic                   pop_done_q, pop_done_d;
   logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
   logic [CHANNELS-1:0]    tx_en_q, tx_en_d;

   logic [DATA_W-1:0]      rx_used_w [CHANNELS];
   logic [DATA_W-1:0]      rx_data_w [CHANNELS];
   logic [CHANNELS-1:0]    chan_oh, hdr_oh, chan_oh_d;
   logic [2*CHANNELS-1:0]  active_buf;
   logic [DATA_W-1:0]      sts_word;
   logic                   hdr_ok;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_split
      assign rx_used_w[g] = rx_used[g*DATA_W +: DATA_W];
      assign rx_data_w[g] = mem_rx_data[g*DATA_W +: DATA_W];
   end

   always_comb begin
      chan_oh = '0;
      chan_oh[chan_q] = 1'b1;
      hdr_oh = '0;
      hdr_oh[hdr_chan[CW-1:0]] = 1'b1;
      hdr_ok = frame_start && (state_q == IDLE) && (hdr_addr == BLOCK_ADDR)
               && ({1'b0, hdr_chan} < 4'(CHANNELS));
      case (state_q)
         SEND:    active_buf = {{CHANNELS{1'b0}}, chan_oh};
         RDATA:   active_buf = {chan_oh, {CHANNELS{1'b0}}};
         default: active_buf = '0;
      endcase
      sts_word = '0;
      if (sts_idx_q == 4'd0)
         sts_word = {BLOCK_ADDR, 8'(CHANNELS)};
      for (int i = 0; i < CHANNELS; i++)
         if (sts_idx_q == 4'(i + 1))
            sts_word = rx_used_w[i];
   end

   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      tx_size_d  = tx_size_q;
      open_d     = '0;
      commit_d   = '0;
      rollback_d = '0;
      sts_idx_d  = sts_idx_q;
      pop_data_d = pop_data_q;
      pop_done_d = 1'b0;
      rst_cnt_d  = (rst_cnt_q != '0) ? rst_cnt_q - RW'(1) : '0;
      if (state_q == IDLE) begin
         if (hdr_ok) begin
            case (hdr_cmd)
               CMD_RESET: rst_cnt_d = RW'(RESET_PULSE);
               CMD_SEND: begin
                  state_d = SEND;
                  chan_d  = hdr_chan[CW-1:0];
                  open_d  = {{CHANNELS{1'b0}}, hdr_oh};
               end
               CMD_STS: begin
                  state_d   = STS;
                  chan_d    = hdr_chan[CW-1:0];
                  tx_size_d = DATA_W'(CHANNELS + 1);
                  sts_idx_d = '0;
               end
               CMD_RDATA: begin
                  state_d   = RDATA;
                  chan_d    = hdr_chan[CW-1:0];
                  tx_size_d = rx_used_w[hdr_chan[CW-1:0]];
                  open_d    = {hdr_oh, {CHANNELS{1'b0}}};
               end
               default: ;
            endcase
         end
      end else begin
         if (state_q == STS && spi_pop_req) begin
            pop_done_d = 1'b1;
            pop_data_d = sts_word;
            if (sts_idx_q < STS_LAST)
               sts_idx_d = sts_idx_q + 4'd1;
         end
         // Abort has priority: a frame that both ends and breaks is treated as broken.
         if (frame_abort) begin
            state_d    = IDLE;
            tx_size_d  = '0;
            rollback_d = active_buf;
         end else if (frame_end) begin
            state_d   = IDLE;
            tx_size_d = '0;
            commit_d  = active_buf;
         end
      end
      chan_oh_d = '0;
      chan_oh_d[chan_d] = 1'b1;
      tx_en_d = (state_d == SEND) ? ~chan_oh_d : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         chan_q     <= '0;
         tx_size_q  <= '0;
         open_q     <= '0;
         commit_q   <= '0;
         rollback_q <= '0;
         sts_idx_q  <= '0;
         pop_data_q <= '0;
         pop_done_q <= 1'b0;
         rst_cnt_q  <= '0;
         tx_en_q    <= '1;
      end else begin
         state_q    <= state_d;
         chan_q     <= chan_d;
         tx_size_q  <= tx_size_d;
         open_q     <= open_d;
         commit_q   <= commit_d;
         rollback_q <= rollback_d;
         sts_idx_q  <= sts_idx_d;
         pop_data_q <= pop_data_d;
         pop_done_q <= pop_done_d;
         rst_cnt_q  <= rst_cnt_d;
         tx_en_q    <= tx_en_d;
      end
   end

   assign mem_tx_data    = (state_q == SEND) ? spi_rx_data : '0;
   assign mem_tx_req     = (state_q == SEND && spi_rx_req) ? chan_oh : '0;
   assign mem_rx_pop_req = (state_q == RDATA && spi_pop_req) ? chan_oh : '0;
   assign spi_pop_data   = (state_q == RDATA) ? rx_data_w[chan_q] :
                           (state_q == STS)   ? pop_data_q : '0;
   assign spi_pop_done   = (state_q == RDATA) ? mem_rx_pop_done[chan_q] :
                           (state_q == STS)   ? pop_done_q : 1'b0;
   assign spi_tx_size    = tx_size_q;
   assign buf_open       = open_q;
   assign buf_commit     = commit_q;
   assign buf_rollback   = rollback_q;
   assign mil_tx_enable  = tx_en_q;
   assign reset_request  = (rst_cnt_q != '0);

endmodule

// File: tb/tb_mil_spi_router.sv
// Directed self-checking bench for mil_spi_router (CHANNELS=2, BLOCK_ADDR=8'hAB, RESET_PULSE=4).
module tb_mil_spi_router;

   logic        clk;
   logic        rst;
   logic        frame_start, frame_end, frame_abort;
   logic [7:0]  hdr_addr;
   logic [3:0]  hdr_cmd;
   logic [2:0]  hdr_chan;
   logic [15:0] spi_rx_data;
   logic        spi_rx_req, spi_pop_req;
   logic [15:0] spi_pop_data;
   logic        spi_pop_done;
   logic [15:0] spi_tx_size;
   logic [15:0] mem_tx_data;
   logic [1:0]  mem_tx_req, mem_rx_pop_req;
   logic [31:0] mem_rx_data;
   logic [1:0]  mem_rx_pop_done;
   logic [31:0] rx_used;
   logic [3:0]  buf_open, buf_commit, buf_rollback;
   logic [1:0]  mil_tx_enable;
   logic        reset_request;

   int vectors;
   int miscompares;

   mil_spi_router #(.CHANNELS(2), .BLOCK_ADDR(8'hAB), .DATA_W(16), .RESET_PULSE(4)) dut (
      .clk(clk), .rst(rst),
      .frame_start(frame_start), .frame_end(frame_end), .frame_abort(frame_abort),
      .hdr_addr(hdr_addr), .hdr_cmd(hdr_cmd), .hdr_chan(hdr_chan),
      .spi_rx_data(spi_rx_data), .spi_rx_req(spi_rx_req), .spi_pop_req(spi_pop_req),
      .spi_pop_data(spi_pop_data), .spi_pop_done(spi_pop_done), .spi_tx_size(spi_tx_size),
      .mem_tx_data(mem_tx_data), .mem_tx_req(mem_tx_req), .mem_rx_pop_req(mem_rx_pop_req),
      .mem_rx_data(mem_rx_data), .mem_rx_pop_done(mem_rx_pop_done), .rx_used(rx_used),
      .buf_open(buf_open), .buf_commit(buf_commit), .buf_rollback(buf_rollback),
      .mil_tx_enable(mil_tx_enable), .reset_request(reset_request)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      frame_start = 0; frame_end = 0; frame_abort = 0;
      hdr_addr = 8'h00; hdr_cmd = 4'd0; hdr_chan = 3'd0;
      spi_rx_data = 16'h0; spi_rx_req = 0; spi_pop_req = 0;
      mem_rx_data = 32'h0; mem_rx_pop_done = 2'b00;
   endtask

   task automatic test_reset();
      clear_inputs();
      rx_used = 32'h0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      vectors++; if (buf_open !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_open: got %b expected 0000", buf_open); end
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_commit: got %b expected 0000", buf_commit); end
      vectors++; if (buf_rollback !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_rollback: got %b expected 0000", buf_rollback); end
      vectors++; if (mil_tx_enable !== 2'b11) begin miscompares++; $display("[TB] FAIL reset_txen: got %b expected 11", mil_tx_enable); end
      vectors++; if (spi_tx_size !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_size: got %h expected 0000", spi_tx_size); end
      vectors++; if (reset_request !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b expected 0", reset_request); end
      vectors++; if (spi_pop_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pop_done: got %b expected 0", spi_pop_done); end
   endtask

   task automatic test_send();
      logic [15:0] words [3];
      words = '{16'h1111, 16'h2222, 16'h3333};
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd2; hdr_chan = 3'd1;
      @(negedge clk);
      vectors++; if (buf_open !== 4'b0000) begin miscompares++; $display("[TB] FAIL send_open_early: got %b expected 0000", buf_open); end
      step(); frame_start = 0;
      @(negedge clk);
      vectors++; if (buf_open !== 4'b0010) begin miscompares++; $display("[TB] FAIL send_open: got %b expected 0010", buf_open); end
      vectors++; if (mil_tx_enable !== 2'b01) begin miscompares++; $display("[TB] FAIL send_txen: got %b expected 01", mil_tx_enable); end
      for (int i = 0; i < 3; i++) begin
         step(); spi_rx_req = 1; spi_rx_data = words[i];
         @(negedge clk);
         vectors++; if (mem_tx_req !== 2'b10) begin miscompares++; $display("[TB] FAIL send_req[%0d]: got %b expected 10", i, mem_tx_req); end
         vectors++; if (mem_tx_data !== words[i]) begin miscompares++; $display("[TB] FAIL send_data[%0d]: got %h expected %h", i, mem_tx_data, words[i]); end
         vectors++; if (buf_open !== 4'b0000) begin miscompares++; $display("[TB] FAIL send_open_pulse[%0d]: got %b expected 0000", i, buf_open); end
         vectors++; if (mil_tx_enable !== 2'b01) begin miscompares++; $display("[TB] FAIL send_txen_hold[%0d]: got %b expected 01", i, mil_tx_enable); end
      end
      step(); spi_rx_req = 0; frame_end = 1;
      @(negedge clk);
      vectors++; if (mem_tx_req !== 2'b00) begin miscompares++; $display("[TB] FAIL send_req_idle: got %b expected 00", mem_tx_req); end
      step(); frame_end = 0;
      @(negedge clk);
      vectors++; if (buf_commit !== 4'b0010) begin miscompares++; $display("[TB] FAIL send_commit: got %b expected 0010", buf_commit); end
      vectors++; if (buf_rollback !== 4'b0000) begin miscompares++; $display("[TB] FAIL send_no_rollback: got %b expected 0000", buf_rollback); end
      vectors++; if (mil_tx_enable !== 2'b11) begin miscompares++; $display("[TB] FAIL send_txen_after: got %b expected 11", mil_tx_enable); end
      step();
      @(negedge clk);
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL send_commit_pulse: got %b expected 0000", buf_commit); end
   endtask

   task automatic test_status();
      logic [15:0] expw [4];
      expw = '{16'hAB02, 16'h0005, 16'h0007, 16'h0000};
      rx_used = {16'd7, 16'd5};
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd3; hdr_chan = 3'd0;
      step(); frame_start = 0;
      @(negedge clk);
      vectors++; if (spi_tx_size !== 16'd3) begin miscompares++; $display("[TB] FAIL sts_size: got %0d expected 3", spi_tx_size); end
      vectors++; if (buf_open !== 4'b0000) begin miscompares++; $display("[TB] FAIL sts_no_open: got %b expected 0000", buf_open); end
      for (int k = 0; k < 4; k++) begin
         step(); spi_pop_req = 1;
         step(); spi_pop_req = 0;
         @(negedge clk);
         vectors++; if (spi_pop_done !== 1'b1) begin miscompares++; $display("[TB] FAIL sts_done[%0d]: got %b expected 1", k, spi_pop_done); end
         vectors++; if (spi_pop_data !== expw[k]) begin miscompares++; $display("[TB] FAIL sts_word[%0d]: got %h expected %h", k, spi_pop_data, expw[k]); end
      end
      step(); frame_end = 1;
      step(); frame_end = 0;
      @(negedge clk);
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL sts_no_commit: got %b expected 0000", buf_commit); end
      vectors++; if (spi_tx_size !== 16'd0) begin miscompares++; $display("[TB] FAIL sts_size_idle: got %0d expected 0", spi_tx_size); end
   endtask

   task automatic test_rdata();
      rx_used = {16'd7, 16'd2};
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd4; hdr_chan = 3'd0;
      step(); frame_start = 0;
      @(negedge clk);
      vectors++; if (buf_open !== 4'b0100) begin miscompares++; $display("[TB] FAIL rd_open: got %b expected 0100", buf_open); end
      vectors++; if (spi_tx_size !== 16'd2) begin miscompares++; $display("[TB] FAIL rd_size: got %0d expected 2", spi_tx_size); end
      step(); spi_pop_req = 1; mem_rx_data = {16'hBEEF, 16'h1234}; mem_rx_pop_done = 2'b01;
      @(negedge clk);
      vectors++; if (mem_rx_pop_req !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_pop_req: got %b expected 01", mem_rx_pop_req); end
      vectors++; if (spi_pop_data !== 16'h1234) begin miscompares++; $display("[TB] FAIL rd_data: got %h expected 1234", spi_pop_data); end
      vectors++; if (spi_pop_done !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_done: got %b expected 1", spi_pop_done); end
      step(); spi_pop_req = 0; mem_rx_pop_done = 2'b10;
      @(negedge clk);
      vectors++; if (spi_pop_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_done_other_chan: got %b expected 0", spi_pop_done); end
      step(); mem_rx_pop_done = 2'b00; frame_abort = 1;
      step(); frame_abort = 0;
      @(negedge clk);
      vectors++; if (buf_rollback !== 4'b0100) begin miscompares++; $display("[TB] FAIL rd_rollback: got %b expected 0100", buf_rollback); end
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL rd_no_commit: got %b expected 0000", buf_commit); end
      vectors++; if (spi_tx_size !== 16'd0) begin miscompares++; $display("[TB] FAIL rd_size_idle: got %0d expected 0", spi_tx_size); end
   endtask

   task automatic test_filtering();
      logic [7:0] addrs [3];
      logic [3:0] cmds  [3];
      logic [2:0] chans [3];
      addrs = '{8'hAC, 8'hAB, 8'hAB};
      cmds  = '{4'd2, 4'd2, 4'd7};
      chans = '{3'd1, 3'd2, 3'd0};
      for (int i = 0; i < 3; i++) begin
         step(); frame_start = 1; hdr_addr = addrs[i]; hdr_cmd = cmds[i]; hdr_chan = chans[i];
         step(); frame_start = 0; spi_rx_req = 1; spi_rx_data = 16'h5A5A;
         @(negedge clk);
         vectors++; if (buf_open !== 4'b0000) begin miscompares++; $display("[TB] FAIL filt_open[%0d]: got %b expected 0000", i, buf_open); end
         vectors++; if (mil_tx_enable !== 2'b11) begin miscompares++; $display("[TB] FAIL filt_txen[%0d]: got %b expected 11", i, mil_tx_enable); end
         vectors++; if (mem_tx_req !== 2'b00) begin miscompares++; $display("[TB] FAIL filt_req[%0d]: got %b expected 00", i, mem_tx_req); end
         vectors++; if (reset_request !== 1'b0) begin miscompares++; $display("[TB] FAIL filt_rreq[%0d]: got %b expected 0", i, reset_request); end
         spi_rx_req = 0;
      end
   endtask

   task automatic test_reset_pulse();
      int high;
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd1; hdr_chan = 3'd0;
      @(negedge clk);
      vectors++; if (reset_request !== 1'b0) begin miscompares++; $display("[TB] FAIL rreq_early: got %b expected 0", reset_request); end
      step(); frame_start = 0;
      high = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (reset_request === 1'b1) high++;
         step();
      end
      vectors++; if (high !== 4) begin miscompares++; $display("[TB] FAIL rreq_len: got %0d cycles expected 4", high); end
      // Second RESET sampled on the edge that opens the second high cycle.
      step(); frame_start = 1;
      step();
      high = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (reset_request === 1'b1) high++;
         if (c == 0) frame_start = 1;
         step();
         frame_start = 0;
      end
      vectors++; if (high !== 5) begin miscompares++; $display("[TB] FAIL rreq_restart_len: got %0d cycles expected 5", high); end
      step(); frame_start = 1;
      step(); frame_start = 0; rst = 1;
      step(); rst = 0;
      @(negedge clk);
      vectors++; if (reset_request !== 1'b0) begin miscompares++; $display("[TB] FAIL rreq_rst_clear: got %b expected 0", reset_request); end
   endtask

   task automatic test_end_abort_same();
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd2; hdr_chan = 3'd0;
      step(); frame_start = 0; frame_end = 1; frame_abort = 1;
      step(); frame_end = 0; frame_abort = 0;
      @(negedge clk);
      vectors++; if (buf_rollback !== 4'b0001) begin miscompares++; $display("[TB] FAIL both_rollback: got %b expected 0001", buf_rollback); end
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL both_no_commit: got %b expected 0000", buf_commit); end
      vectors++; if (mil_tx_enable !== 2'b11) begin miscompares++; $display("[TB] FAIL both_txen: got %b expected 11", mil_tx_enable); end
   endtask

   task automatic test_rst_midframe();
      step(); frame_start = 1; hdr_addr = 8'hAB; hdr_cmd = 4'd2; hdr_chan = 3'd1;
      step(); frame_start = 0; rst = 1;
      step(); rst = 0; frame_end = 1;
      @(negedge clk);
      vectors++; if (mil_tx_enable !== 2'b11) begin miscompares++; $display("[TB] FAIL rstmid_txen: got %b expected 11", mil_tx_enable); end
      vectors++; if (buf_rollback !== 4'b0000) begin miscompares++; $display("[TB] FAIL rstmid_rollback: got %b expected 0000", buf_rollback); end
      step(); frame_end = 0;
      @(negedge clk);
      vectors++; if (buf_commit !== 4'b0000) begin miscompares++; $display("[TB] FAIL rstmid_commit: got %b expected 0000", buf_commit); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_send();
      test_status();
      test_rdata();
      test_filtering();
      test_reset_pulse();
      test_end_abort_same();
      test_rst_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
